// File: rtl/forwarding_hazard_unit.sv
// Operand bypass and load-use hazard unit for N producer stages (index 0 = youngest).
// Optional FWD_STATS_EN adds free-running forward/stall cycle counters.
module forwarding_hazard_unit #(
    parameter int NSRC     = 3,
    parameter int REGW     = 5,
    parameter int DW       = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NSRC-1:0]      src_wen,
    input  logic [NSRC*REGW-1:0] src_wsel,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic [NSRC-1:0]      src_ld,
    input  logic                 c_valid,
    input  logic [REGW-1:0]      rsel1,
    input  logic [REGW-1:0]      rsel2,
    input  logic                 use_rs2,
    input  logic                 is_store,
    input  logic [DW-1:0]        rdat1,
    input  logic [DW-1:0]        rdat2,
    output logic [DW-1:0]        opA,
    output logic [DW-1:0]        opB,
    output logic [DW-1:0]        st_data,
    output logic                 stall,
    output logic                 fsm_state
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]          fwd_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_load;

    logic          hit1, ld1, late1, hit2, ld2, late2;
    logic [DW-1:0] dat1, dat2;
    logic [CW-1:0] need1, need2;
    logic          en2, fwd2, haz1, haz2, hazard;
    logic          hold_a_v, hold_b_v;
    logic [DW-1:0] hold_a, hold_b, r2;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit1 = 1'b0; ld1 = 1'b0; late1 = 1'b0; dat1 = '0; need1 = '0;
        hit2 = 1'b0; ld2 = 1'b0; late2 = 1'b0; dat2 = '0; need2 = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_wen[i] && src_wsel[i*REGW +: REGW] == rsel1 && rsel1 != '0) begin
                hit1  = 1'b1;
                dat1  = src_data[i*DW +: DW];
                ld1   = src_ld[i];
                late1 = src_ld[i] && (LOAD_LAT > i);
                need1 = CW'(LOAD_LAT - i - 1);
            end
            if (src_wen[i] && src_wsel[i*REGW +: REGW] == rsel2 && rsel2 != '0) begin
                hit2  = 1'b1;
                dat2  = src_data[i*DW +: DW];
                ld2   = src_ld[i];
                late2 = src_ld[i] && (LOAD_LAT > i);
                need2 = CW'(LOAD_LAT - i - 1);
            end
        end
    end

    assign en2    = use_rs2 | is_store;
    assign fwd2   = hit2 & en2;
    assign haz1   = c_valid & hit1 & late1;
    assign haz2   = c_valid & fwd2 & late2;
    assign hazard = haz1 | haz2;
    assign cnt_load = (haz1 && (!haz2 || need1 > need2)) ? need1 : need2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!c_valid) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        state_nxt = STALL;
                        cnt_nxt   = cnt_load;
                    end
                end
                STALL: begin
                    if (hazard) begin
                        cnt_nxt = cnt_load;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall     = c_valid & (hazard | (state == STALL && cnt != '0));
        fsm_state = state;
        opA       = hit1 ? dat1 : (hold_a_v ? hold_a : rdat1);
        r2        = fwd2 ? dat2 : (hold_b_v ? hold_b : rdat2);
        opB       = use_rs2 ? r2 : rdat2;
        st_data   = is_store ? r2 : rdat2;
    end

    // Keep bypassed values alive while stalled; the producer may retire meanwhile.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_a_v <= 1'b0;
            hold_b_v <= 1'b0;
            hold_a   <= '0;
            hold_b   <= '0;
        end else if (!c_valid || !stall) begin
            hold_a_v <= 1'b0;
            hold_b_v <= 1'b0;
        end else begin
            if (hit1 && !ld1) begin
                hold_a   <= dat1;
                hold_a_v <= 1'b1;
            end
            if (fwd2 && !ld2) begin
                hold_b   <= dat2;
                hold_b_v <= 1'b1;
            end
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (c_valid && (hit1 || fwd2)) fwd_cnt <= fwd_cnt + 32'd1;
            if (stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
